// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Registered RV32I (+ optional RV32M) instruction decoder between fetch and
// execute. Each accepted instruction word is decoded into a compact numeric
// control code. The code, the register fields and the PC are held in a single
// output register stage with valid/ready flow control.
//
// Illegal encodings produce an all-ones control code and raise out_illegal.
// A saturating counter tallies every accepted, non-flushed illegal word.
//
// Parameters
//   CTRL_W : control code width (must be >= 6; codes are zero-extended)
//   PC_W   : PC passthrough width
//   EN_M   : 1 = decode RV32M mul/div, 0 = treat them as illegal
//   CNT_W  : width of the saturating illegal-instruction counter
//
// Ports
//   clk, rst_n          : clock (rising edge), async active-low reset
//   flush               : kills the held result and the same-cycle input
//   in_valid / in_ready : fetch-side handshake
//   in_instr, in_pc     : raw instruction word and its PC
//   out_valid/out_ready : execute-side handshake
//   out_ctrl            : decoded control code (all ones when illegal)
//   out_rd/rs1/rs2      : instr[11:7], instr[19:15], instr[24:20]
//   out_pc              : registered PC
//   out_illegal         : held instruction is illegal
//   illegal_cnt         : saturating count of accepted illegal instructions
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int CTRL_W = 6,
  parameter int PC_W   = 32,
  parameter bit EN_M   = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  // Major opcodes. All legal opcodes end in 2'b11, so an instruction with
  // instr[1:0] != 2'b11 can never match and falls into the illegal default.
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Control codes
  localparam logic [5:0] C_ADD   = 6'd0;
  localparam logic [5:0] C_SUB   = 6'd1;
  localparam logic [5:0] C_SLL   = 6'd2;
  localparam logic [5:0] C_SLT   = 6'd3;
  localparam logic [5:0] C_SLTU  = 6'd4;
  localparam logic [5:0] C_XOR   = 6'd5;
  localparam logic [5:0] C_SRL   = 6'd6;
  localparam logic [5:0] C_SRA   = 6'd7;
  localparam logic [5:0] C_OR    = 6'd8;
  localparam logic [5:0] C_AND   = 6'd9;
  localparam logic [5:0] C_ADDI  = 6'd10;
  localparam logic [5:0] C_SLTI  = 6'd11;
  localparam logic [5:0] C_SLTIU = 6'd12;
  localparam logic [5:0] C_XORI  = 6'd13;
  localparam logic [5:0] C_ORI   = 6'd14;
  localparam logic [5:0] C_ANDI  = 6'd15;
  localparam logic [5:0] C_SLLI  = 6'd16;
  localparam logic [5:0] C_SRLI  = 6'd17;
  localparam logic [5:0] C_SRAI  = 6'd18;
  localparam logic [5:0] C_LB    = 6'd19;
  localparam logic [5:0] C_LH    = 6'd20;
  localparam logic [5:0] C_LW    = 6'd21;
  localparam logic [5:0] C_LBU   = 6'd22;
  localparam logic [5:0] C_LHU   = 6'd23;
  localparam logic [5:0] C_SB    = 6'd24;
  localparam logic [5:0] C_SH    = 6'd25;
  localparam logic [5:0] C_SW    = 6'd26;
  localparam logic [5:0] C_BEQ   = 6'd27;
  localparam logic [5:0] C_BNE   = 6'd28;
  localparam logic [5:0] C_BLT   = 6'd29;
  localparam logic [5:0] C_BGE   = 6'd30;
  localparam logic [5:0] C_BLTU  = 6'd31;
  localparam logic [5:0] C_BGEU  = 6'd32;
  localparam logic [5:0] C_LUI   = 6'd33;
  localparam logic [5:0] C_AUIPC = 6'd34;
  localparam logic [5:0] C_JAL   = 6'd35;
  localparam logic [5:0] C_JALR  = 6'd36;
  localparam logic [5:0] C_MUL   = 6'd37;  // mul..remu occupy 37..44 in funct3 order

  // Returns {illegal, code}. code is zero whenever illegal is set, so every
  // path produces a defined value.
  function automatic logic [6:0] decode_word(input logic [31:0] instr);
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ill;
    logic [5:0] code;
    opcode = instr[6:0];
    f3     = instr[14:12];
    f7     = instr[31:25];
    ill    = 1'b0;
    code   = 6'd0;
    case (opcode)
      OP_R: begin
        if (f7 == F7_BASE) begin
          case (f3)
            3'd0:    code = C_ADD;
            3'd1:    code = C_SLL;
            3'd2:    code = C_SLT;
            3'd3:    code = C_SLTU;
            3'd4:    code = C_XOR;
            3'd5:    code = C_SRL;
            3'd6:    code = C_OR;
            default: code = C_AND;
          endcase
        end else if (f7 == F7_ALT) begin
          case (f3)
            3'd0:    code = C_SUB;
            3'd5:    code = C_SRA;
            default: ill  = 1'b1;
          endcase
        end else if (EN_M && (f7 == F7_MULDIV)) begin
          code = C_MUL + {3'b000, f3};
        end else begin
          ill = 1'b1;
        end
      end
      OP_I: begin
        case (f3)
          3'd0: code = C_ADDI;
          3'd2: code = C_SLTI;
          3'd3: code = C_SLTIU;
          3'd4: code = C_XORI;
          3'd6: code = C_ORI;
          3'd7: code = C_ANDI;
          // Shift-immediates reuse funct7 as an opcode extension
          3'd1: begin
            if (f7 == F7_BASE) code = C_SLLI;
            else               ill  = 1'b1;
          end
          default: begin
            if      (f7 == F7_BASE) code = C_SRLI;
            else if (f7 == F7_ALT)  code = C_SRAI;
            else                    ill  = 1'b1;
          end
        endcase
      end
      OP_LOAD: begin
        case (f3)
          3'd0:    code = C_LB;
          3'd1:    code = C_LH;
          3'd2:    code = C_LW;
          3'd4:    code = C_LBU;
          3'd5:    code = C_LHU;
          default: ill  = 1'b1;
        endcase
      end
      OP_STORE: begin
        case (f3)
          3'd0:    code = C_SB;
          3'd1:    code = C_SH;
          3'd2:    code = C_SW;
          default: ill  = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        case (f3)
          3'd0:    code = C_BEQ;
          3'd1:    code = C_BNE;
          3'd4:    code = C_BLT;
          3'd5:    code = C_BGE;
          3'd6:    code = C_BLTU;
          3'd7:    code = C_BGEU;
          default: ill  = 1'b1;
        endcase
      end
      OP_LUI:   code = C_LUI;
      OP_AUIPC: code = C_AUIPC;
      OP_JAL:   code = C_JAL;
      OP_JALR: begin
        if (f3 == 3'd0) code = C_JALR;
        else            ill  = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    return {ill, code};
  endfunction

  logic              vld_q,  vld_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [4:0]        rd_q,   rd_d;
  logic [4:0]        rs1_q,  rs1_d;
  logic [4:0]        rs2_q,  rs2_d;
  logic [PC_W-1:0]   pc_q,   pc_d;
  logic              ill_q,  ill_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  logic              accept;
  logic [6:0]        dec;
  logic [CTRL_W-1:0] dec_ctrl;

  always_comb begin
    dec      = decode_word(in_instr);
    dec_ctrl = '0;
    if (dec[6]) dec_ctrl = '1;
    else        dec_ctrl[5:0] = dec[5:0];
  end

  // Fetch -> decode register boundary
  always_comb begin
    in_ready = !vld_q || out_ready;
    // Flush suppresses capture, but in_ready itself is not gated by it
    accept   = in_valid && in_ready && !flush;

    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    rd_d   = rd_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    pc_d   = pc_q;
    ill_d  = ill_q;
    cnt_d  = cnt_q;

    if (flush) begin
      vld_d = 1'b0;
    end else if (accept) begin
      vld_d  = 1'b1;
      ctrl_d = dec_ctrl;
      rd_d   = in_instr[11:7];
      rs1_d  = in_instr[19:15];
      rs2_d  = in_instr[24:20];
      pc_d   = in_pc;
      ill_d  = dec[6];
      if (dec[6] && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      pc_q   <= '0;
      ill_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      ctrl_q <= ctrl_d;
      rd_q   <= rd_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      pc_q   <= pc_d;
      ill_q  <= ill_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid   = vld_q;
  assign out_ctrl    = ctrl_q;
  assign out_rd      = rd_q;
  assign out_rs1     = rs1_q;
  assign out_rs2     = rs2_q;
  assign out_pc      = pc_q;
  assign out_illegal = ill_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked successor to the combinational instruction-control decoder.
- Takes a raw 32-bit RV32 instruction word plus its PC from fetch and decodes opcode, funct3 and funct7 into the team's numeric control code.
- Flags illegal encodings and counts them; optional M-extension decode.
- One pipeline-register stage between fetch and execute, with valid/ready flow control and flush.

Parameters:
- CTRL_W, 6, control code width; must be >= 6.
- PC_W, 32, PC passthrough width.
- EN_M, 0, 1 = decode RV32M mul/div; 0 = treat them as illegal.
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of held and incoming instruction.
- in_valid  input  1  fetch offers an instruction.
- in_ready  output  1  stage accepts this cycle.
- in_instr  input  32  raw instruction word.
- in_pc  input  PC_W  instruction PC.
- out_valid  output  1  decoded result held.
- out_ready  input  1  execute accepts.
- out_ctrl  output  CTRL_W  control code.
- out_rd, out_rs1, out_rs2  output  5 each  register fields (instr[11:7], [19:15], [24:20]).
- out_pc  output  PC_W  registered PC.
- out_illegal  output  1  decoded instruction is illegal.
- illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_ctrl=0, out_rd/rs1/rs2=0, out_pc=0, out_illegal=0, illegal_cnt=0.
- Handshake: in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready: decoded fields load on that edge; out_valid=1 next cycle; latency 1 cycle.
  - Hold: out_valid && !out_ready keeps all out_* stable; in_ready=0.
  - Transfer to execute occurs when out_valid && out_ready; with no new accept, out_valid clears.
  - Back-to-back: full throughput, one instruction per cycle when out_ready is held high.
- Flush has priority over everything:
  - Next cycle out_valid=0.
  - The same-cycle input is not captured and illegal_cnt does not count it.
  - in_ready stays as defined; flush does not deassert it.
- Opcode map (instr[6:0]):
  - R 0110011, I 0010011, Load 0000011, Store 0100011, Branch 1100011.
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
- Control codes (decimal, zero-extended to CTRL_W):
  - R-type, funct7=0000000: add 0, sll 2, slt 3, sltu 4, xor 5, srl 6, or 8, and 9.
  - R-type, funct7=0100000: sub 1, sra 7.
  - I-type: addi 10, slti 11, sltiu 12, xori 13, ori 14, andi 15.
  - Shift-immediate: slli 16 (funct7 must be 0), srli 17 (funct7=0000000), srai 18 (funct7=0100000). srli and srai are distinct codes.
  - Loads: lb 19, lh 20, lw 21, lbu 22, lhu 23.
  - Stores: sb 24, sh 25, sw 26.
  - Branches: beq 27, bne 28, blt 29, bge 30, bltu 31, bgeu 32.
  - lui 33, auipc 34, jal 35, jalr 36 (JALR requires funct3=000).
  - EN_M=1, R-type funct7=0000001, funct3 0..7 maps to 37..44: mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
- Illegal instructions:
  - Definition: any unlisted opcode, funct3/funct7 combination, or instr[1:0]!=11.
  - Response: out_ctrl = all ones and out_illegal=1. No X is ever driven.
  - Register fields and PC still pass through.
- illegal_cnt:
  - Increments on each accepted (non-flushed) illegal instruction.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Reset only via rst_n.
- Reset mid-operation: a held instruction is discarded and the counter is cleared immediately, without waiting for a clock.

Test Plan:
- Reset then feed add x3,x1,x2 (0x002081B3) with out_ready=1:
  - Next cycle out_valid=1, out_ctrl=0, rd=3, rs1=1, rs2=2.
  - in_ready stays 1.
- srai x5,x5,3 (0x4032D293) -> out_ctrl=18; srli x5,x5,3 (0x0032D293) -> out_ctrl=17.
- Backpressure:
  - Accept lw (0x0000A103); hold out_ready=0 for 3 cycles.
  - Required: out_ctrl=21 stable, in_ready=0, a new offered instruction is not taken.
  - Raise out_ready: the new instruction appears the following cycle.
- mul x1,x2,x3 (0x023100B3):
  - EN_M=0 -> out_illegal=1, out_ctrl=63, illegal_cnt=1.
  - EN_M=1 -> out_ctrl=37, out_illegal=0, counter unchanged.
- Flush asserted with in_valid=1 carrying 0xFFFFFFFF while a jal is held:
  - Next cycle out_valid=0.
  - illegal_cnt unchanged.
- CNT_W=2:
  - Send 5 illegal words -> illegal_cnt sequence 1,2,3,3,3.
  - Assert rst_n=0 between clock edges -> counter and out_valid go to 0 immediately.
